// File: rtl/seg7_capture.sv
// seg7_capture: passive reader of a multiplexed 7-segment bus that emits one event per changed digit
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   an_n       anode enables, active-low, bit i selects digit i
//   a_to_g     segment lines, active-low, bit 6 = a .. bit 0 = g
//   out_valid  change event available (held until out_ready)
//   out_ready  consumer accepts the event
//   out_digit  index of the changed digit
//   out_char   decoded ASCII of the changed digit
//   frame      current ASCII of every digit, digit i at [8i+7:8i]
//   multi_err  one-cycle pulse: stable sample with more than one anode low
//   drop       one-cycle pulse: change seen while the output register was full and not draining
module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    input  logic [6:0]                    a_to_g,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_DIGITS)-1:0] out_digit,
    output logic [7:0]                    out_char,
    output logic [8*NUM_DIGITS-1:0]       frame,
    output logic                          multi_err,
    output logic                          drop
);
    localparam int SW = NUM_DIGITS + 7;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {SETTLE, STABLE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           sync_q, samp_q, prev_q;
    logic [NUM_DIGITS-1:0]   shadow_valid_q;
    logic [8*NUM_DIGITS-1:0] frame_q;
    logic                    out_valid_q, multi_err_q, drop_q;
    logic [DW-1:0]           out_digit_q;
    logic [7:0]              out_char_q;

    logic                  capture, one_hot, multi, change, load;
    logic [NUM_DIGITS-1:0] low;
    logic [DW-1:0]         idx;
    logic [7:0]            ch;

    function automatic logic [7:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: return 8'h30;
            7'b1001111: return 8'h31;
            7'b0010010: return 8'h32;
            7'b0000110: return 8'h33;
            7'b1001100: return 8'h34;
            7'b0100100: return 8'h35;
            7'b0100000: return 8'h36;
            7'b0001111: return 8'h37;
            7'b0000000: return 8'h38;
            7'b0000100: return 8'h39;
            7'b0001000: return 8'h61;
            7'b1100000: return 8'h62;
            7'b0110001: return 8'h63;
            7'b1000010: return 8'h64;
            7'b0110000: return 8'h65;
            7'b0111000: return 8'h66;
            7'b1001000: return 8'h68;
            7'b1111001: return 8'h69;
            7'b1000011: return 8'h6A;
            7'b1110001: return 8'h6C;
            7'b1101010: return 8'h6E;
            7'b1100010: return 8'h6F;
            7'b0011000: return 8'h70;
            7'b0001100: return 8'h71;
            7'b1000001: return 8'h75;
            7'b1111111: return 8'h20;
            default:    return 8'h3F;
        endcase
    endfunction

    // Stability FSM: a capture fires once, after STABLE_CYCLES unchanged samples following a change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (samp_q != prev_q) begin
            state_d = SETTLE;
            cnt_d   = '0;
        end else if (state_q == SETTLE) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            if (cnt_q == CNT_MAX) begin
                capture = 1'b1;
                state_d = STABLE;
            end
        end
    end

    // Classify the captured sample and decide between loading an event and dropping it
    always_comb begin
        low = ~samp_q[SW-1:7];
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (low[i]) idx = DW'(i);
        one_hot = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
        multi   = (low != '0) && !one_hot;
        ch      = decode(samp_q[6:0]);
        // frame doubles as the per-digit shadow of the last emitted character
        change  = capture && one_hot && (!shadow_valid_q[idx] || frame_q[8*idx +: 8] != ch);
        load    = change && (!out_valid_q || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q         <= '1;
            samp_q         <= '1;
            prev_q         <= '1;
            state_q        <= SETTLE;
            cnt_q          <= '0;
            shadow_valid_q <= '0;
            frame_q        <= {NUM_DIGITS{8'h20}};
            out_valid_q    <= 1'b0;
            out_digit_q    <= '0;
            out_char_q     <= 8'h00;
            multi_err_q    <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            sync_q      <= {an_n, a_to_g};
            samp_q      <= sync_q;
            prev_q      <= samp_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            multi_err_q <= capture && multi;
            drop_q      <= change && !load;
            out_valid_q <= load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
            if (load) begin
                out_digit_q            <= idx;
                out_char_q             <= ch;
                frame_q[8*idx +: 8]    <= ch;
                shadow_valid_q[idx]    <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_char  = out_char_q;
    assign frame     = frame_q;
    assign multi_err = multi_err_q;
    assign drop      = drop_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized and directed checks of seg7_capture against a behavioural model
module tb_seg7_capture;
    localparam int N  = 4;
    localparam int SC = 4;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P8 = 7'b0000000;
    localparam logic [6:0] PA = 7'b0001000, PB = 7'b1100000;

    logic         clk = 1'b0, rst_n = 1'b1, out_ready = 1'b0;
    logic [N-1:0] an_n = '1;
    logic [6:0]   a_to_g = '1;
    logic         out_valid, multi_err, drop;
    logic [1:0]   out_digit;
    logic [7:0]   out_char;
    logic [8*N-1:0] frame;

    seg7_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .an_n(an_n), .a_to_g(a_to_g),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_char(out_char), .frame(frame), .multi_err(multi_err), .drop(drop)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int ev_n = 0, drop_n = 0, multi_n = 0;
    logic [7:0] ev_ch[$];
    logic [1:0] ev_dg[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sample is captured once it has persisted SC cycles past its arrival
    logic [7:0]  tbl[128];
    logic [10:0] m_d1, m_s;
    int          m_age;
    logic [7:0]  m_sh[N];
    logic        m_shv[N];
    logic        m_valid, m_multi, m_drop, ov;
    logic [1:0]  m_digit;
    logic [7:0]  m_char, c;
    logic [3:0]  low;
    int          d;

    initial begin
        for (int i = 0; i < 128; i++) tbl[i] = 8'h3F;
        tbl[7'b0000001] = 8'h30; tbl[7'b1001111] = 8'h31; tbl[7'b0010010] = 8'h32;
        tbl[7'b0000110] = 8'h33; tbl[7'b1001100] = 8'h34; tbl[7'b0100100] = 8'h35;
        tbl[7'b0100000] = 8'h36; tbl[7'b0001111] = 8'h37; tbl[7'b0000000] = 8'h38;
        tbl[7'b0000100] = 8'h39; tbl[7'b0001000] = 8'h61; tbl[7'b1100000] = 8'h62;
        tbl[7'b0110001] = 8'h63; tbl[7'b1000010] = 8'h64; tbl[7'b0110000] = 8'h65;
        tbl[7'b0111000] = 8'h66; tbl[7'b1001000] = 8'h68; tbl[7'b1111001] = 8'h69;
        tbl[7'b1000011] = 8'h6A; tbl[7'b1110001] = 8'h6C; tbl[7'b1101010] = 8'h6E;
        tbl[7'b1100010] = 8'h6F; tbl[7'b0011000] = 8'h70; tbl[7'b0001100] = 8'h71;
        tbl[7'b1000001] = 8'h75; tbl[7'b1111111] = 8'h20;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_d1 = '1; m_s = '1; m_age = 1;
                m_valid = 0; m_digit = 0; m_char = 0; m_multi = 0; m_drop = 0;
                for (int k = 0; k < N; k++) begin m_sh[k] = 8'h20; m_shv[k] = 0; end
            end else begin
                ov = m_valid; m_multi = 0; m_drop = 0;
                if (m_valid && out_ready) m_valid = 0;
                if (m_age == SC) begin
                    low = ~m_s[10:7];
                    if ($countones(low) > 1) m_multi = 1;
                    else if ($countones(low) == 1) begin
                        for (int k = 0; k < N; k++) if (low[k]) d = k;
                        c = tbl[m_s[6:0]];
                        if (!m_shv[d] || m_sh[d] != c) begin
                            if (!ov || out_ready) begin
                                m_valid = 1; m_digit = 2'(d); m_char = c; m_sh[d] = c; m_shv[d] = 1;
                            end else m_drop = 1;
                        end
                    end
                end
                if (m_d1 != m_s) m_age = 0; else if (m_age < 1000) m_age++;
                m_s = m_d1;
                m_d1 = {an_n, a_to_g};
            end
        end
    end

    // Compare and monitor on the falling edge, away from DUT updates and input drives
    initial forever begin
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_digit", 32'(out_digit), 32'(m_digit));
        chk("out_char", 32'(out_char), 32'(m_char));
        chk("frame", frame, {m_sh[3], m_sh[2], m_sh[1], m_sh[0]});
        chk("multi_err", 32'(multi_err), 32'(m_multi));
        chk("drop", 32'(drop), 32'(m_drop));
        if (out_valid && out_ready) begin ev_ch.push_back(out_char); ev_dg.push_back(out_digit); ev_n++; end
        if (drop) drop_n++;
        if (multi_err) multi_n++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic show(input int dg, input logic [6:0] seg, input int n);
        an_n = ~(4'b1 << dg);
        a_to_g = seg;
        cyc(n);
    endtask

    logic [6:0] pats[8] = '{P0, P1, P2, P3, P4, P5, PA, PB};
    int e0, d0, m0, r;

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_frame", frame, 32'h20202020);
        chk("rst_digit", 32'(out_digit), 0);
        chk("rst_char", 32'(out_char), 0);
        rst_n = 1'b1;
        cyc(2);
        an_n = 4'b1110; a_to_g = P2;
        cyc(6);
        chk("first_early", 32'(out_valid), 0);
        cyc(1);
        chk("first_valid", 32'(out_valid), 1);
        chk("first_digit", 32'(out_digit), 0);
        chk("first_char", 32'(out_char), 32'h32);
        chk("first_frame", 32'(frame[7:0]), 32'h32);
        out_ready = 1'b1;
        cyc(3);
        e0 = ev_n;
        for (int rnd = 0; rnd < 2; rnd++) begin
            show(0, P1, 10); show(1, P2, 10); show(2, PA, 10); show(3, PB, 10);
            chk("round_events", 32'(ev_n - e0), 4);
        end
        chk("round_c0", 32'(ev_ch[e0]), 32'h31);
        chk("round_c1", 32'(ev_ch[e0+1]), 32'h32);
        chk("round_c2", 32'(ev_ch[e0+2]), 32'h61);
        chk("round_c3", 32'(ev_ch[e0+3]), 32'h62);
        chk("round_d3", 32'(ev_dg[e0+3]), 3);

        out_ready = 1'b0; e0 = ev_n; d0 = drop_n;
        show(0, P3, 10); show(1, P4, 10); show(2, PA, 10); show(3, PB, 10);
        chk("drop_count", 32'(drop_n - d0), 1);
        chk("held_char", 32'(out_char), 32'h33);
        out_ready = 1'b1;
        show(0, P3, 10); show(1, P4, 10);
        chk("redetect_events", 32'(ev_n - e0), 2);
        chk("redetect_c0", 32'(ev_ch[e0]), 32'h33);
        chk("redetect_c1", 32'(ev_ch[e0+1]), 32'h34);
        chk("redetect_d1", 32'(ev_dg[e0+1]), 1);

        show(0, P0, 10);
        e0 = ev_n;
        show(0, P1, 3); show(0, P0, 12);
        chk("glitch_events", 32'(ev_n - e0), 0);
        chk("glitch_frame", 32'(frame[7:0]), 32'h30);

        e0 = ev_n; m0 = multi_n;
        an_n = 4'b1100; a_to_g = P8;
        cyc(12);
        chk("multi_count", 32'(multi_n - m0), 1);
        chk("multi_events", 32'(ev_n - e0), 0);
        show(2, 7'b1010101, 12);
        chk("unknown_char", 32'(ev_ch[ev_n-1]), 32'h3F);
        show(2, 7'b0100000, 12);
        chk("six_char", 32'(ev_ch[ev_n-1]), 32'h36);

        out_ready = 1'b0;
        show(3, P5, 10);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_frame", frame, 32'h20202020);
        chk("mid_rst_char", 32'(out_char), 0);
        chk("mid_rst_digit", 32'(out_digit), 0);
        cyc(1);
        #1 rst_n = 1'b1;
        cyc(7);
        chk("reemit_valid", 32'(out_valid), 1);
        chk("reemit_digit", 32'(out_digit), 3);
        chk("reemit_char", 32'(out_char), 32'h35);
        out_ready = 1'b1;
        cyc(3);

        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            d0 = $urandom_range(0, 3);
            an_n = (r == 0) ? 4'hF : (r == 1) ? 4'($urandom_range(0, 15)) : ~(4'b1 << d0);
            a_to_g = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pats[$urandom_range(0, 7)];
            out_ready = ($urandom_range(0, 3) != 0);
            cyc($urandom_range(1, 14));
        end
        cyc(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Passive reader for the multiplexed 7-segment display bus: it samples the active-low anode lines and `a_to_g` segment lines driven by the display controller, and waits for each digit's pattern to be stable. It then decodes the pattern back to ASCII and emits one valid/ready event for each digit whose character changed. It sits beside the display driver in self-test builds and lets a UART or logic-analyzer path read back the displayed text.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `STABLE_CYCLES`, 16: consecutive identical synchronized samples required before capture (≥2).
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `an_n` in NUM_DIGITS: anode enables, active-low; bit i selects digit i.
- `a_to_g` in 7: segment lines, active-low; bit 6 = a, bit 0 = g.
- `out_valid` out 1: change event available.
- `out_ready` in 1: consumer accepts the event.
- `out_digit` out clog2(NUM_DIGITS): index of the changed digit.
- `out_char` out 8: decoded ASCII.
- `frame` out 8*NUM_DIGITS: current ASCII of all digits; digit i is at `[8i+7:8i]`.
- `multi_err` out 1: one-cycle pulse when a stable sample has more than one anode low.
- `drop` out 1: one-cycle pulse when a change is detected while the output register is full and not being emptied.

## Operation
- Synchronizer: `{an_n, a_to_g}` passes through 2 flops. All logic below uses the synchronized sample S.
- Stability FSM: states SETTLE and STABLE; a counter `cnt` tracks consecutive equal samples.
  - In any state, if S ≠ previous S, the FSM goes to SETTLE and `cnt` is set to 0.
  - In SETTLE with S unchanged: `cnt` increments. When `cnt == STABLE_CYCLES-1`, a capture is performed and the FSM moves to STABLE.
  - In STABLE with S unchanged: no action, so there is exactly one capture per stable period.
- Capture classification:
  - `an_n` all ones: blanking interval; ignored.
  - More than one `an_n` bit low: pulse `multi_err`; nothing is recorded.
  - Exactly one bit i low: decode `a_to_g` to character C. If `shadow_valid[i]` is 0 or `shadow[i]` ≠ C, this is a change event.
- Decode (pattern → ASCII):
  - Digits and hex letters: 0000001→30, 1001111→31, 0010010→32, 0000110→33, 1001100→34, 0100100→35, 0100000→36, 0001111→37, 0000000→38, 0000100→39, 0001000→61, 1100000→62, 0110001→63, 1000010→64, 0110000→65, 0111000→66.
  - Other letters: 1001000→68, 1111001→69, 1000011→6A, 1110001→6C, 1101010→6E, 1100010→6F, 0011000→70, 0001100→71, 1000001→75.
  - Blank: 1111111→20 (space).
  - Any other pattern → 3F ('?').
  - Aliased glyphs resolve to the digit or 'a': g→'6', s→'5', r→'a'.
- Change event handling:
  - If `out_valid` is 0, or `out_valid && out_ready` in the same cycle, load `out_digit`/`out_char`. `out_valid` is 1 next cycle; `shadow[i]`, `shadow_valid[i]` and `frame` digit i are updated on the same edge.
  - Otherwise pulse `drop` and leave the shadow unchanged. The display's next refresh of digit i re-detects the change, so no event is permanently lost.
- Handshake: `out_valid` stays high with stable `out_digit`/`out_char` until `out_ready`. On the accepting edge it clears, unless a new event loads on that same edge.
- Reset (async, `rst_n` low), effective immediately mid-operation:
  - `out_valid`=0, `out_digit`=0, `out_char`=0x00, `multi_err`=0, `drop`=0.
  - `frame` = all 0x20.
  - `shadow_valid`=0, synchronizer flops = all ones, FSM=SETTLE, `cnt`=0.
  - Any pending event is discarded.

## Timing
- Pins change at edge 0 and then hold: S is updated at edge 2, SETTLE/`cnt`=0 at edge 3, capture at edge STABLE_CYCLES+3. `out_valid` and `frame` update on that same edge.
- A pin glitch shorter than STABLE_CYCLES+1 cycles produces no event.
- `multi_err` and `drop` pulse on the capture edge and last 1 cycle.
- `cnt` saturates; it never wraps in STABLE.
- Throughput: at most one event per stable period; no combinational path from `out_ready` to any output.

## Test plan
- STABLE_CYCLES=4. Reset, then drive `an_n`=1110, `a_to_g`=0010010 → `out_valid` rises at edge 7, `out_digit`=0, `out_char`=0x32, `frame[7:0]`=0x32.
- Cycle the 4 digits through "12ab", one digit every 10 cycles with `out_ready`=1 → 4 events in order with chars 31,32,61,62. A second identical refresh round → no events.
- Hold `out_ready`=0 while two digits change → the first event is held and `drop` pulses once. Release `out_ready` → the dropped digit is emitted on its next refresh.
- Drive a 3-cycle glitch to 1001111 on a stable digit 0x30 → no event, `frame` unchanged.
- Drive `an_n`=1100 stable → `multi_err` pulses once and there is no event. Drive pattern 1010101 → `out_char`=0x3F. Drive 0100000 → 0x36.
- Assert `rst_n` low while `out_valid`=1 → all outputs return to reset values immediately. After release, the first capture re-emits the currently displayed digit.
